// File: rtl/pe_pkg.sv
// Shared types and constants for the conv processing element.
// Latency: n/a (definitions only).
// Backpressure: n/a.
package pe_pkg;

  localparam string MODE_STR_RELU    = "relu";
  localparam string MODE_STR_DEQUANT = "dequant";
  localparam string MODE_STR_SIGMOID = "sigmoid";

  localparam logic [31:0] LAYER_SCALE_BASE_ADDR = 32'h1000;
  localparam int          ACC_W                 = 32;
  localparam logic [15:0] SCALE_RESET           = 16'h0100;

  typedef enum logic [1:0] {
    MODE_RELU,
    MODE_DEQUANT,
    MODE_SIGMOID
  } out_mode_e;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_MAC,
    ST_POST
  } pe_state_e;

  // Output lane width: relu lanes are bytes, the other modes carry int16/Q8.8.
  function automatic int lane_w(input out_mode_e mode);
    return (mode == MODE_RELU) ? 8 : 16;
  endfunction

endpackage

// File: rtl/pe_post_proc.sv
// Activation stage: maps a bias-added accumulator to one output lane.
// Latency: combinational.
// Backpressure: none; caller samples the lane when it needs it.
module pe_post_proc
  import pe_pkg::*;
#(
  parameter out_mode_e MODE      = MODE_RELU,
  parameter int        OUT_SHIFT = 8,
  parameter int        W         = 8
) (
  input  logic signed [ACC_W-1:0] y,
  input  logic        [15:0]      scale,
  output logic        [W-1:0]     lane
);

  logic signed [ACC_W-1:0] y_sh;
  logic signed [47:0]      prod;
  logic signed [47:0]      prod_sh;
  logic signed [15:0]      z;
  logic signed [16:0]      sig_t;
  logic        [7:0]       relu_v;
  logic        [15:0]      sig_v;

  // Evaluate all three activations and select the configured one.
  always_comb begin
    // relu: requantise by OUT_SHIFT and clamp into a byte
    y_sh = y >>> OUT_SHIFT;
    if (y < 0) begin
      relu_v = 8'd0;
    end else if (y_sh > ACC_W'(255)) begin
      relu_v = 8'hFF;
    end else begin
      relu_v = y_sh[7:0];
    end

    // dequant: scale is unsigned Q8.8, product kept wide enough not to overflow
    prod    = 48'(y) * 48'($signed({1'b0, scale}));
    prod_sh = prod >>> 8;
    if (prod_sh > 48'sd32767) begin
      z = 16'sh7FFF;
    end else if (prod_sh < -48'sd32768) begin
      z = 16'sh8000;
    end else begin
      z = prod_sh[15:0];
    end

    // hard sigmoid in Q8.8: 0.25*z + 0.5, clamped to [0, 1.0]
    sig_t = 17'(z >>> 2) + 17'sd128;
    if (sig_t < 0) begin
      sig_v = 16'd0;
    end else if (sig_t > 17'sd256) begin
      sig_v = 16'h0100;
    end else begin
      sig_v = sig_t[15:0];
    end

    case (MODE)
      MODE_DEQUANT: lane = W'(z);
      MODE_SIGMOID: lane = W'(sig_v);
      default:      lane = W'(relu_v);
    endcase
  end

endmodule

// File: rtl/pe_incha_single.sv
// Conv PE: one int8 patch in, OUT_CHANNEL activated dot products out, all lanes together.
// Latency: OUT_CHANNEL*(KERNEL_PTS+1) cycles from accept to o_valid.
// Backpressure: pe_ready low while computing; results are a pulse, no output stall.
module pe_incha_single
  import pe_pkg::*;
#(
  parameter int    IN_WIDTH    = 3,
  parameter int    IN_HEIGHT   = 3,
  parameter int    IN_CHANNEL  = 2,
  parameter int    OUT_CHANNEL = 4,
  parameter string OUTPUT_MODE = "relu",
  parameter int    KERNEL_0    = 3,
  parameter int    KERNEL_1    = 3,
  parameter int    DILATION_0  = 1,
  parameter int    DILATION_1  = 1,
  parameter int    PADDING_0   = 1,
  parameter int    PADDING_1   = 1,
  parameter int    STRIDE_0    = 1,
  parameter int    STRIDE_1    = 1,
  parameter int    OUT_SHIFT   = 8,
  localparam int        KERNEL_PTS = KERNEL_0 * KERNEL_1,
  localparam out_mode_e MODE       = (OUTPUT_MODE == MODE_STR_DEQUANT) ? MODE_DEQUANT :
                                     (OUTPUT_MODE == MODE_STR_SIGMOID) ? MODE_SIGMOID : MODE_RELU,
  localparam int        W          = lane_w(MODE)
) (
  input  logic                                clk,
  input  logic                                rst_n,
  input  logic [8*IN_CHANNEL*KERNEL_PTS-1:0]  i_data,
  input  logic                                i_valid,
  output logic                                pe_ready,
  output logic                                pe_ack,
  output logic [W*OUT_CHANNEL-1:0]            o_data,
  output logic                                o_valid,
  input  logic [15:0]                         weight_wr_data,
  input  logic [31:0]                         weight_wr_addr,
  input  logic                                weight_wr_en
);

  localparam int PATCH_N = IN_CHANNEL * KERNEL_PTS;
  localparam int NW      = OUT_CHANNEL * PATCH_N;
  localparam int OC_W    = (OUT_CHANNEL > 1) ? $clog2(OUT_CHANNEL) : 1;
  localparam int KP_W    = (KERNEL_PTS > 1) ? $clog2(KERNEL_PTS) : 1;
  localparam int WA_W    = (NW > 1) ? $clog2(NW) : 1;
  localparam int XB_W    = $clog2(8 * PATCH_N);

  logic signed [7:0]          weight [NW];
  logic signed [15:0]         bias   [OUT_CHANNEL];
  logic        [15:0]         scale;

  pe_state_e                  state;
  pe_state_e                  state_nxt;
  logic                       accept;
  logic                       last_kp;
  logic                       last_oc;

  logic [OC_W-1:0]            oc;
  logic [KP_W-1:0]            kp;
  logic signed [ACC_W-1:0]    acc;
  logic signed [ACC_W-1:0]    mac_sum;
  logic signed [ACC_W-1:0]    y_post;
  logic [8*PATCH_N-1:0]       x_lat;
  logic [W-1:0]               lane_val;
  logic [W*OUT_CHANNEL-1:0]   staging;
  logic [W*OUT_CHANNEL-1:0]   staging_nxt;

  assign pe_ready = (state == ST_IDLE);
  assign last_kp  = (kp == KP_W'(KERNEL_PTS - 1));
  assign last_oc  = (oc == OC_W'(OUT_CHANNEL - 1));

  // Parameter write port: weights at the bottom of the map, bias/scale above the base address.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NW; i++) weight[i] <= '0;
      for (int i = 0; i < OUT_CHANNEL; i++) bias[i] <= '0;
      scale <= SCALE_RESET;
    end else if (weight_wr_en) begin
      for (int i = 0; i < NW; i++) begin
        if (weight_wr_addr == 32'(i)) weight[i] <= weight_wr_data[7:0];
      end
      for (int i = 0; i < OUT_CHANNEL; i++) begin
        if (weight_wr_addr == LAYER_SCALE_BASE_ADDR + 32'(i)) bias[i] <= weight_wr_data;
      end
      if (weight_wr_addr == LAYER_SCALE_BASE_ADDR + 32'(OUT_CHANNEL)) scale <= weight_wr_data;
    end
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  // Next state: IDLE -> MAC (KERNEL_PTS cycles) -> POST -> MAC for next lane or back to IDLE.
  always_comb begin
    state_nxt = state;
    accept    = 1'b0;
    case (state)
      ST_IDLE: begin
        if (i_valid) begin
          accept    = 1'b1;
          state_nxt = ST_MAC;
        end
      end
      ST_MAC:  if (last_kp) state_nxt = ST_POST;
      ST_POST: state_nxt = last_oc ? ST_IDLE : ST_MAC;
      default: state_nxt = ST_IDLE;
    endcase
  end

  // One kernel point across all input channels; activations are unsigned, weights signed.
  always_comb begin
    mac_sum = '0;
    for (int ic = 0; ic < IN_CHANNEL; ic++) begin
      logic [7:0]         xb;
      logic signed [16:0] p;
      xb = x_lat[XB_W'(8 * (int'(kp) * IN_CHANNEL + ic)) +: 8];
      p  = 17'($signed({1'b0, xb})) *
           17'(weight[WA_W'(int'(oc) * PATCH_N + int'(kp) * IN_CHANNEL + ic)]);
      mac_sum = mac_sum + ACC_W'(p);
    end
  end

  assign y_post = acc + ACC_W'(bias[oc]);

  pe_post_proc #(
    .MODE      (MODE),
    .OUT_SHIFT (OUT_SHIFT),
    .W         (W)
  ) u_post (
    .y     (y_post),
    .scale (scale),
    .lane  (lane_val)
  );

  // Staging with the current lane merged in; the last lane goes straight to o_data.
  always_comb begin
    staging_nxt = staging;
    for (int i = 0; i < OUT_CHANNEL; i++) begin
      if (oc == OC_W'(i)) staging_nxt[W*i +: W] = lane_val;
    end
  end

  // Datapath: latch patch, accumulate, post-process each lane, publish the full vector.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      oc      <= '0;
      kp      <= '0;
      acc     <= '0;
      x_lat   <= '0;
      staging <= '0;
      o_data  <= '0;
      o_valid <= 1'b0;
      pe_ack  <= 1'b0;
    end else begin
      pe_ack  <= accept;
      o_valid <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (accept) begin
            x_lat <= i_data;
            oc    <= '0;
            kp    <= '0;
            acc   <= '0;
          end
        end
        ST_MAC: begin
          acc <= acc + mac_sum;
          if (!last_kp) kp <= kp + KP_W'(1);
        end
        ST_POST: begin
          staging <= staging_nxt;
          acc     <= '0;
          kp      <= '0;
          if (last_oc) begin
            o_data  <= staging_nxt;
            o_valid <= 1'b1;
          end else begin
            oc <= oc + OC_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_pe_incha_single.sv
// Bench for pe_incha_single: relu, dequant and sigmoid instances share stimulus.
// Scoreboard pushes model results on pe_ack and pops them on o_valid.
// Table of patch/weight vectors plus hand-written handshake and reset sequences.
module tb_pe_incha_single;

  logic         clk = 1'b0;
  logic         rst_n;
  logic [143:0] i_data;
  logic         i_valid;
  logic [15:0]  wr_dat;
  logic [31:0]  wr_addr;
  logic         wr_en;

  logic        rdy_r, ack_r, ov_r;
  logic [31:0] od_r;
  logic        rdy_d, ack_d, ov_d;
  logic [63:0] od_d;
  logic        rdy_s, ack_s, ov_s;
  logic [63:0] od_s;

  int cyc   = 0;
  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  pe_incha_single #(.OUTPUT_MODE("relu")) u_relu (
    .clk(clk), .rst_n(rst_n), .i_data(i_data), .i_valid(i_valid),
    .pe_ready(rdy_r), .pe_ack(ack_r), .o_data(od_r), .o_valid(ov_r),
    .weight_wr_data(wr_dat), .weight_wr_addr(wr_addr), .weight_wr_en(wr_en)
  );

  pe_incha_single #(.OUTPUT_MODE("dequant")) u_deq (
    .clk(clk), .rst_n(rst_n), .i_data(i_data), .i_valid(i_valid),
    .pe_ready(rdy_d), .pe_ack(ack_d), .o_data(od_d), .o_valid(ov_d),
    .weight_wr_data(wr_dat), .weight_wr_addr(wr_addr), .weight_wr_en(wr_en)
  );

  pe_incha_single #(.OUTPUT_MODE("sigmoid")) u_sig (
    .clk(clk), .rst_n(rst_n), .i_data(i_data), .i_valid(i_valid),
    .pe_ready(rdy_s), .pe_ack(ack_s), .o_data(od_s), .o_valid(ov_s),
    .weight_wr_data(wr_dat), .weight_wr_addr(wr_addr), .weight_wr_en(wr_en)
  );

  // Shadow of the parameter memories, maintained from the write map.
  logic signed [7:0]  wm [72];
  logic signed [15:0] bm [4];
  logic        [15:0] sm;

  typedef struct {
    logic [31:0] r;
    logic [63:0] d;
    logic [63:0] s;
    int          acc_cyc;
  } exp_t;
  exp_t sbq[$];
  exp_t mon_e;

  typedef struct {
    int          wsel;
    logic [63:0] bias;
    logic [7:0]  xb;
    logic [31:0] exp_r;
    logic [15:0] exp_d0;
  } vec_t;
  vec_t vt[5];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] want);
    total++;
    if (act !== want) begin
      bad++;
      $display("FAIL %s: got %h expected %h", nm, act, want);
    end
  endtask

  function automatic void reset_shadow();
    for (int i = 0; i < 72; i++) wm[i] = '0;
    for (int i = 0; i < 4; i++) bm[i] = '0;
    sm = 16'h0100;
  endfunction

  function automatic longint calc_y(input logic [143:0] p, input int oc);
    longint s = 0;
    for (int j = 0; j < 18; j++) s += longint'(p[8*j +: 8]) * longint'(wm[oc*18 + j]);
    return s + longint'(bm[oc]);
  endfunction

  function automatic exp_t mdl(input logic [143:0] p);
    exp_t e;
    e.r = '0; e.d = '0; e.s = '0; e.acc_cyc = 0;
    for (int oc = 0; oc < 4; oc++) begin
      longint y, z, t, rq;
      y  = calc_y(p, oc);
      rq = (y < 0) ? 0 : ((y >>> 8) > 255 ? 255 : (y >>> 8));
      z  = (y * longint'(sm)) >>> 8;
      if (z > 32767) z = 32767;
      if (z < -32768) z = -32768;
      t  = (z >>> 2) + 128;
      if (t < 0) t = 0;
      if (t > 256) t = 256;
      e.r[8*oc +: 8]   = rq[7:0];
      e.d[16*oc +: 16] = z[15:0];
      e.s[16*oc +: 16] = t[15:0];
    end
    return e;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [31:0] a, input logic [15:0] d);
    wr_addr = a; wr_dat = d; wr_en = 1'b1;
    tick();
    wr_en = 1'b0;
    if (a < 32'd72) wm[a] = d[7:0];
    else if (a >= 32'h1000 && a < 32'h1004) bm[a - 32'h1000] = d;
    else if (a == 32'h1004) sm = d;
  endtask

  task automatic load(input int wsel, input logic [63:0] b);
    for (int i = 0; i < 72; i++) begin
      logic [7:0] d;
      d = (wsel == 0) ? 8'((i % 18) + 1) : (wsel == 1) ? 8'h7F : 8'hFF;
      wr(32'(i), {8'h5A, d});
    end
    for (int oc = 0; oc < 4; oc++) wr(32'h1000 + 32'(oc), b[16*oc +: 16]);
  endtask

  task automatic send(input logic [7:0] xb);
    bit ok = 0;
    i_data  = {18{xb}};
    i_valid = 1'b1;
    for (int k = 0; k < 100 && !ok; k++) begin
      @(negedge clk);
      if (ack_r) begin
        exp_t e;
        ok = 1;
        e = mdl(i_data);
        e.acc_cyc = cyc;
        sbq.push_back(e);
      end
    end
    if (!ok) begin
      total++; bad++;
      $display("FAIL accept_timeout: no pe_ack within 100 cycles");
    end
    tick();
    i_valid = 1'b0;
  endtask

  task automatic drain();
    for (int k = 0; k < 200 && sbq.size() != 0; k++) @(negedge clk);
    chk("drain_pending", 64'(sbq.size()), 64'd0);
    sbq.delete();
    tick();
  endtask

  // Output monitor: every o_valid must match the oldest expected result.
  always @(negedge clk) begin
    if (rst_n && ov_r) begin
      if (sbq.size() == 0) begin
        total++; bad++;
        $display("FAIL unexpected_o_valid: got o_data %h with nothing outstanding", od_r);
      end else begin
        mon_e = sbq.pop_front();
        chk("relu_data", 64'(od_r), 64'(mon_e.r));
        chk("deq_data", od_d, mon_e.d);
        chk("sig_data", od_s, mon_e.s);
        chk("latency", 64'(cyc - mon_e.acc_cyc), 64'd40);
        chk("ready_in_valid_cycle", 64'(rdy_r), 64'd1);
        chk("modes_valid_together", 64'({ov_d, ov_s}), 64'd3);
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int c1, c2;
    bit got;
    vt[0] = '{0, {16'd30, 16'd20, 16'd10, 16'd0},  8'hAA, 32'h71717171, 16'h718E};
    vt[1] = '{1, 64'h0,                            8'hFF, 32'hFFFFFFFF, 16'h7FFF};
    vt[2] = '{0, {16'h0, 16'h0, 16'h0, 16'h8000},  8'h00, 32'h00000000, 16'h8000};
    vt[3] = '{0, 64'h0,                            8'h10, 32'h0A0A0A0A, 16'h0AB0};
    vt[4] = '{2, {16'd5000, 16'h0, 16'h0, 16'h0},  8'hFF, 32'h01000000, 16'hEE12};

    reset_shadow();
    rst_n = 1'b0; i_valid = 1'b0; i_data = '0;
    wr_en = 1'b0; wr_addr = '0; wr_dat = '0;
    repeat (3) @(negedge clk);
    chk("rst_ready_relu", 64'(rdy_r), 64'd1);
    chk("rst_ready_deq", 64'(rdy_d), 64'd1);
    chk("rst_ready_sig", 64'(rdy_s), 64'd1);
    chk("rst_ack_relu", 64'(ack_r), 64'd0);
    chk("rst_ack_deq", 64'(ack_d), 64'd0);
    chk("rst_ack_sig", 64'(ack_s), 64'd0);
    chk("rst_valid_relu", 64'(ov_r), 64'd0);
    chk("rst_valid_deq", 64'(ov_d), 64'd0);
    chk("rst_valid_sig", 64'(ov_s), 64'd0);
    chk("rst_data_relu", 64'(od_r), 64'd0);
    chk("rst_data_deq", od_d, 64'd0);
    chk("rst_data_sig", od_s, 64'd0);
    rst_n = 1'b1;
    tick();

    // Table-driven patches.
    for (int v = 0; v < 5; v++) begin
      load(vt[v].wsel, vt[v].bias);
      send(vt[v].xb);
      if (v == 0) begin
        @(negedge clk);
        chk("ack_pulse_width", 64'(ack_r), 64'd0);
        tick();
      end
      drain();
      chk($sformatf("vec%0d_relu", v), 64'(od_r), 64'(vt[v].exp_r));
      chk($sformatf("vec%0d_deq_lane0", v), 64'(od_d[15:0]), 64'(vt[v].exp_d0));
    end

    // Non-unity layer scale: 0.5 halves the dequant result.
    load(0, vt[0].bias);
    wr(32'h1004, 16'h0080);
    send(8'hAA);
    drain();
    chk("scale_half_lane0", 64'(od_d[15:0]), 64'h38C7);
    wr(32'h1004, 16'h0100);

    // Handshake: i_valid stays high; only one accept until the o_valid cycle.
    i_data = {18{8'hAA}};
    i_valid = 1'b1;
    got = 0; c1 = 0;
    for (int k = 0; k < 100 && !got; k++) begin
      @(negedge clk);
      if (ack_r) begin
        exp_t e;
        got = 1; c1 = cyc;
        e = mdl(i_data); e.acc_cyc = cyc; sbq.push_back(e);
      end
    end
    chk("hs_first_accept", 64'(got), 64'd1);
    tick();
    i_data = {18{8'h10}};
    got = 0; c2 = 0;
    for (int k = 0; k < 100 && !got; k++) begin
      @(negedge clk);
      if (ack_r) begin
        exp_t e;
        got = 1; c2 = cyc;
        e = mdl(i_data); e.acc_cyc = cyc; sbq.push_back(e);
      end
    end
    chk("hs_second_accept", 64'(got), 64'd1);
    chk("hs_accept_gap", 64'(c2 - c1), 64'd41);
    tick();
    i_valid = 1'b0;
    drain();
    chk("hs_second_relu", 64'(od_r), 64'h0A0A0A0A);

    // Reset in the middle of a computation.
    load(0, vt[0].bias);
    send(8'hAA);
    repeat (19) @(negedge clk);
    rst_n = 1'b0;
    sbq.delete();
    @(negedge clk);
    chk("midrst_ready", 64'(rdy_r), 64'd1);
    chk("midrst_valid", 64'(ov_r), 64'd0);
    chk("midrst_data_relu", 64'(od_r), 64'd0);
    chk("midrst_data_deq", od_d, 64'd0);
    rst_n = 1'b1;
    reset_shadow();
    repeat (50) @(negedge clk);
    chk("post_rst_ready", 64'(rdy_r), 64'd1);
    tick();
    send(8'h00);
    drain();
    chk("sigmoid_zero", od_s, 64'h0080008000800080);
    send(8'hAA);
    drain();
    chk("post_rst_weights_relu", 64'(od_r), 64'd0);
    chk("post_rst_weights_deq", od_d, 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
